// File: rtl/banked_image_mem_pkg.sv
// Shared types and default geometry for the banked image memory.
// Bank storage and collision policy are described in mem_bank / banked_image_mem.
package banked_mem_pkg;

    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        READY = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 18;
    localparam int DEF_DEPTH  = 5120;
    localparam int DEF_BANKS  = 2;

endpackage

// File: rtl/banked_image_mem_if.sv
// Access bus of banked_image_mem: per-bank packed read/write ports plus clear/status.
interface banked_image_mem_if #(
    parameter int DATA_W = 18,
    parameter int ADDR_W = 13,
    parameter int BANKS  = 2
);
    logic [BANKS-1:0]        rd_en;
    logic [BANKS*ADDR_W-1:0] rd_addr;
    logic [BANKS*DATA_W-1:0] rd_data;
    logic [BANKS-1:0]        rd_valid;
    logic [BANKS-1:0]        wr_en;
    logic [BANKS*ADDR_W-1:0] wr_addr;
    logic [BANKS*DATA_W-1:0] wr_data;
    logic                    clr_req;
    logic                    busy;
    logic                    err_oob;

    modport master (
        output rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        input  rd_data, rd_valid, busy, err_oob
    );

    modport slave (
        input  rd_en, rd_addr, wr_en, wr_addr, wr_data, clr_req,
        output rd_data, rd_valid, busy, err_oob
    );
endinterface

// File: rtl/banked_image_mem_bank.sv
// mem_bank: one 1R1W bank with registered read, out-of-range detection and collision mux.
// Collision policy: write-first when BANKED_MEM_BYPASS_EN is defined, read-first otherwise.
module mem_bank #(
    parameter int DATA_W = 18,
    parameter int DEPTH  = 5120,
    parameter int ADDR_W = 13
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    input  logic              i_wr_en,
    input  logic [ADDR_W-1:0] i_wr_addr,
    input  logic [DATA_W-1:0] i_wr_data,
    input  logic              i_clr_en,
    input  logic [ADDR_W-1:0] i_clr_addr,
    output logic [DATA_W-1:0] o_rd_data,
    output logic              o_rd_valid,
    output logic              o_oob
);
    localparam logic [ADDR_W:0] DEPTH_EXT = (ADDR_W+1)'(DEPTH);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_rd_data;
    logic              r_rd_valid;
    logic              w_rd_oob;
    logic              w_wr_oob;
    logic              w_we;
    logic [ADDR_W-1:0] w_waddr;
    logic [DATA_W-1:0] w_wdata;
    logic [DATA_W-1:0] w_rd_word;

    assign w_rd_oob = ({1'b0, i_rd_addr} >= DEPTH_EXT);
    assign w_wr_oob = ({1'b0, i_wr_addr} >= DEPTH_EXT);
    assign o_oob    = (i_rd_en & w_rd_oob) | (i_wr_en & w_wr_oob);

    // Single write port shared by the clear engine and external writes
    always_comb begin
        w_we    = 1'b0;
        w_waddr = i_wr_addr;
        w_wdata = i_wr_data;
        if (i_clr_en) begin
            w_we    = 1'b1;
            w_waddr = i_clr_addr;
            w_wdata = {DATA_W{1'b0}};
        end else begin
            w_we    = i_wr_en & ~w_wr_oob;
        end
    end

    // Storage array, left unreset so it maps onto block RAM
    always_ff @(posedge i_clk) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
    end

    // Read word selection: out-of-range reads return zero
    always_comb begin
        w_rd_word = {DATA_W{1'b0}};
        if (w_rd_oob) begin
            w_rd_word = {DATA_W{1'b0}};
`ifdef BANKED_MEM_BYPASS_EN
        end else if (i_wr_en && !w_wr_oob && (i_wr_addr == i_rd_addr)) begin
            w_rd_word = i_wr_data;
`endif
        end else begin
            w_rd_word = r_mem[i_rd_addr];
        end
    end

    // Registered read port; data holds when no read is issued
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_rd_data  <= {DATA_W{1'b0}};
            r_rd_valid <= 1'b0;
        end else begin
            r_rd_valid <= i_rd_en;
            if (i_rd_en) begin
                r_rd_data <= w_rd_word;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
endmodule

// File: rtl/banked_image_mem.sv
// banked_image_mem: BANKS independent 1R1W banks with a clear engine and sticky OOB flag.
// Optional macro BANKED_MEM_BYPASS_EN selects write-first collision behaviour.
module banked_image_mem
    import banked_mem_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH,
    parameter int BANKS  = DEF_BANKS
) (
    input  logic               clk,
    input  logic               rst_n,
    banked_image_mem_if.slave  bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    state_t            r_state;
    state_t            w_next_state;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic [ADDR_W-1:0] w_next_cnt;
    logic              r_busy;
    logic              r_err_oob;
    logic              w_ready;
    logic [BANKS-1:0]  w_rd_en;
    logic [BANKS-1:0]  w_wr_en;
    logic [BANKS-1:0]  w_oob;

    assign w_ready = (r_state == READY);
    assign w_rd_en = bus.rd_en & {BANKS{w_ready}};
    assign w_wr_en = bus.wr_en & {BANKS{w_ready}};

    // State, clear counter, busy and sticky error registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= CLEAR;
            r_clr_cnt <= {ADDR_W{1'b0}};
            r_busy    <= 1'b1;
            r_err_oob <= 1'b0;
        end else begin
            r_state   <= w_next_state;
            r_clr_cnt <= w_next_cnt;
            r_busy    <= (w_next_state == CLEAR);
            r_err_oob <= r_err_oob | (|w_oob);
        end
    end

    // Next-state logic: clear sweeps every address once, clr_req only honoured in READY
    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_clr_cnt;
        case (r_state)
            CLEAR: begin
                if (r_clr_cnt == LAST_ADDR) begin
                    w_next_state = READY;
                    w_next_cnt   = {ADDR_W{1'b0}};
                end else begin
                    w_next_cnt   = r_clr_cnt + {{(ADDR_W-1){1'b0}}, 1'b1};
                end
            end
            READY: begin
                if (bus.clr_req) begin
                    w_next_state = CLEAR;
                    w_next_cnt   = {ADDR_W{1'b0}};
                end else begin
                    w_next_state = READY;
                end
            end
            default: begin
                w_next_state = CLEAR;
                w_next_cnt   = {ADDR_W{1'b0}};
            end
        endcase
    end

    for (genvar b = 0; b < BANKS; b++) begin : g_bank
        mem_bank #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH),
            .ADDR_W (ADDR_W)
        ) u_bank (
            .i_clk      (clk),
            .i_rst_n    (rst_n),
            .i_rd_en    (w_rd_en[b]),
            .i_rd_addr  (bus.rd_addr[b*ADDR_W +: ADDR_W]),
            .i_wr_en    (w_wr_en[b]),
            .i_wr_addr  (bus.wr_addr[b*ADDR_W +: ADDR_W]),
            .i_wr_data  (bus.wr_data[b*DATA_W +: DATA_W]),
            .i_clr_en   (~w_ready),
            .i_clr_addr (r_clr_cnt),
            .o_rd_data  (bus.rd_data[b*DATA_W +: DATA_W]),
            .o_rd_valid (bus.rd_valid[b]),
            .o_oob      (w_oob[b])
        );
    end

    assign bus.busy    = r_busy;
    assign bus.err_oob = r_err_oob;
endmodule

// File: tb/tb_banked_image_mem.sv
// Directed bench for banked_image_mem (DATA_W=18, DEPTH=5120, BANKS=2): vector table plus
// hand sequences for clear timing, clear-during-access and reset mid-clear.
module tb_banked_image_mem;
    localparam int DW    = 18;
    localparam int DEPTH = 5120;
    localparam int AW    = 13;
    localparam int NB    = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    banked_image_mem_if #(.DATA_W(DW), .ADDR_W(AW), .BANKS(NB)) bus ();

    banked_image_mem #(.DATA_W(DW), .DEPTH(DEPTH), .BANKS(NB)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    typedef struct {
        string       name;
        int          bank;
        bit          we;
        bit          re;
        logic [AW-1:0] addr;
        logic [DW-1:0] wdata;
        logic [DW-1:0] exp_data;
        bit          exp_valid;
        bit          exp_oob;
    } vec_t;

    vec_t vecs[14];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_bus();
        bus.rd_en   = '0;
        bus.wr_en   = '0;
        bus.clr_req = 1'b0;
    endtask

    // Counts cycles with busy high starting at the current sample point
    task automatic count_busy(output int cnt);
        cnt = 0;
        while (bus.busy === 1'b1 && cnt < DEPTH + 20) begin
            cnt++;
            @(negedge clk);
        end
    endtask

    logic [DW-1:0] collide_exp;
    int            busy_cnt;
    bit            valid_seen;

    initial begin
`ifdef BANKED_MEM_BYPASS_EN
        collide_exp = 18'd9;
`else
        collide_exp = 18'd3;
`endif
        vecs[0]  = '{"rd_b0_4000",    0, 1'b0, 1'b1, 13'd4000, 18'h0,     18'h0,     1'b1, 1'b0};
        vecs[1]  = '{"wr_b1_17",      1, 1'b1, 1'b0, 13'd17,   18'h2A5A5, 18'h0,     1'b0, 1'b0};
        vecs[2]  = '{"rd_b1_17",      1, 1'b0, 1'b1, 13'd17,   18'h0,     18'h2A5A5, 1'b1, 1'b0};
        vecs[3]  = '{"rd_b0_17",      0, 1'b0, 1'b1, 13'd17,   18'h0,     18'h0,     1'b1, 1'b0};
        vecs[4]  = '{"wr_b0_5",       0, 1'b1, 1'b0, 13'd5,    18'd3,     18'h0,     1'b0, 1'b0};
        vecs[5]  = '{"collide_b0_5",  0, 1'b1, 1'b1, 13'd5,    18'd9,     collide_exp, 1'b1, 1'b0};
        vecs[6]  = '{"rd_b0_5_after", 0, 1'b0, 1'b1, 13'd5,    18'h0,     18'd9,     1'b1, 1'b0};
        vecs[7]  = '{"wr_b0_oob",     0, 1'b1, 1'b0, 13'd5200, 18'h155,   18'd9,     1'b0, 1'b1};
        vecs[8]  = '{"rd_b0_oob",     0, 1'b0, 1'b1, 13'd5200, 18'h0,     18'h0,     1'b1, 1'b1};
        vecs[9]  = '{"rd_b0_80",      0, 1'b0, 1'b1, 13'd80,   18'h0,     18'h0,     1'b1, 1'b1};
        vecs[10] = '{"rd_b0_1104",    0, 1'b0, 1'b1, 13'd1104, 18'h0,     18'h0,     1'b1, 1'b1};
        vecs[11] = '{"rd_b0_5119",    0, 1'b0, 1'b1, 13'd5119, 18'h0,     18'h0,     1'b1, 1'b1};
        vecs[12] = '{"wr_b1_0",       1, 1'b1, 1'b0, 13'd0,    18'h3FFFF, 18'h2A5A5, 1'b0, 1'b1};
        vecs[13] = '{"rd_b1_0",       1, 1'b0, 1'b1, 13'd0,    18'h0,     18'h3FFFF, 1'b1, 1'b1};

        idle_bus();
        bus.rd_addr = '0;
        bus.wr_addr = '0;
        bus.wr_data = '0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_busy", 32'(bus.busy), 32'd1);
        check("rst_err_oob", 32'(bus.err_oob), 32'd0);
        check("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
        check("rst_rd_data", 32'(bus.rd_data), 32'd0);

        // Post-reset clear length
        rst_n = 1'b1;
        count_busy(busy_cnt);
        check("init_clear_cycles", 32'(busy_cnt), 32'(DEPTH));

        // Table-driven single-bank accesses
        for (int i = 0; i < 14; i++) begin
            idle_bus();
            bus.rd_en[vecs[i].bank] = vecs[i].re;
            bus.wr_en[vecs[i].bank] = vecs[i].we;
            bus.rd_addr[vecs[i].bank*AW +: AW] = vecs[i].addr;
            bus.wr_addr[vecs[i].bank*AW +: AW] = vecs[i].addr;
            bus.wr_data[vecs[i].bank*DW +: DW] = vecs[i].wdata;
            @(negedge clk);
            check({vecs[i].name, "_data"}, 32'(bus.rd_data[vecs[i].bank*DW +: DW]), 32'(vecs[i].exp_data));
            check({vecs[i].name, "_valid"}, 32'(bus.rd_valid[vecs[i].bank]), 32'(vecs[i].exp_valid));
            check({vecs[i].name, "_other_valid"}, 32'(bus.rd_valid[1 - vecs[i].bank]), 32'd0);
            check({vecs[i].name, "_oob"}, 32'(bus.err_oob), 32'(vecs[i].exp_oob));
        end

        // Both banks write then read in the same cycles
        idle_bus();
        bus.wr_en   = 2'b11;
        bus.wr_addr = {13'd100, 13'd100};
        bus.wr_data = {18'h222, 18'h111};
        @(negedge clk);
        idle_bus();
        bus.rd_en   = 2'b11;
        bus.rd_addr = {13'd100, 13'd100};
        @(negedge clk);
        check("dual_rd_data", 32'(bus.rd_data), 32'({18'h222, 18'h111}));
        check("dual_rd_valid", 32'(bus.rd_valid), 32'd3);

        // Fill 0..9 with 7 in both banks
        for (int a = 0; a < 10; a++) begin
            idle_bus();
            bus.wr_en   = 2'b11;
            bus.wr_addr = {13'(a), 13'(a)};
            bus.wr_data = {18'd7, 18'd7};
            @(negedge clk);
        end

        // clr_req with a concurrent read: the read still completes
        idle_bus();
        bus.clr_req = 1'b1;
        bus.rd_en   = 2'b01;
        bus.rd_addr = {13'd0, 13'd3};
        @(negedge clk);
        check("clr_cycle_rd_data", 32'(bus.rd_data[DW-1:0]), 32'd7);
        check("clr_cycle_rd_valid", 32'(bus.rd_valid[0]), 32'd1);
        bus.clr_req = 1'b0;
        busy_cnt = 1;
        valid_seen = 1'b0;
        @(negedge clk);
        // Repeated clr_req mid-clear must not restart the sweep
        bus.clr_req = 1'b1;
        while (bus.busy === 1'b1 && busy_cnt < DEPTH + 20) begin
            busy_cnt++;
            if (bus.rd_valid !== 2'b00) valid_seen = 1'b1;
            @(negedge clk);
            bus.clr_req = 1'b0;
        end
        bus.rd_en = '0;
        check("clr_req_busy_cycles", 32'(busy_cnt), 32'(DEPTH));
        check("rd_valid_during_clear", 32'(valid_seen), 32'd0);
        check("oob_sticky_after_clear", 32'(bus.err_oob), 32'd1);

        // Everything zero after clear
        for (int a = 0; a < 10; a++) begin
            idle_bus();
            bus.rd_en   = 2'b11;
            bus.rd_addr = {13'(a), 13'(a)};
            @(negedge clk);
            check($sformatf("post_clear_rd_%0d", a), 32'(bus.rd_data), 32'd0);
        end

        // Reset asserted at clear cycle 3000 restarts the sweep
        idle_bus();
        bus.clr_req = 1'b1;
        @(negedge clk);
        idle_bus();
        repeat (3000) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midclr_rst_busy", 32'(bus.busy), 32'd1);
        check("midclr_rst_err_oob", 32'(bus.err_oob), 32'd0);
        check("midclr_rst_rd_data", 32'(bus.rd_data), 32'd0);
        rst_n = 1'b1;
        count_busy(busy_cnt);
        check("midclr_restart_cycles", 32'(busy_cnt), 32'(DEPTH));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
